// File: rtl/nv_fifo_ctl_128x6.sv
// Valid/ready flow-control front end for a 128x6 two-port flop RAM with a 4-entry output queue.
// Optional RAM bypass for writes into an empty pipeline is enabled by NV_FIFO_CTL_BYPASS_EN.
module nv_fifo_ctl_128x6 (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [5:0]  wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [5:0]  rd_pd,
    output logic [6:0]  ram_wa,
    output logic        ram_we,
    output logic [5:0]  ram_di,
    output logic [6:0]  ram_ra,
    output logic        ram_re,
    output logic        ram_ore,
    input  logic [5:0]  ram_dout,
    input  logic [31:0] pwrbus_ram_pd,
    output logic [31:0] ram_pwrbus_ram_pd,
    output logic [7:0]  count
);

    logic [6:0] wr_ptr_q, wr_ptr_d;
    logic [6:0] rd_ptr_q, rd_ptr_d;
    logic [7:0] ram_cnt_q, ram_cnt_d;
    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic [2:0] q_cnt_q, q_cnt_d;
    logic [1:0] q_wp_q, q_wp_d;
    logic [1:0] q_rp_q, q_rp_d;
    logic [5:0] q_mem_q [4];
    logic [5:0] q_mem_d [4];
    logic [7:0] count_q, count_d;

    logic       wr_acc;
    logic       pop;
    logic       issue;
    logic       bypass;
    logic       push;
    logic [5:0] push_data;
    logic [3:0] q_busy;
    logic [3:0] q_after_pop;

    always_comb begin
        rd_pvld     = (q_cnt_q != 3'd0);
        pop         = rd_pvld & rd_prdy;
        // Write slot depends on registered RAM occupancy only; a same-cycle issue never frees it.
        wr_prdy     = !rst && (ram_cnt_q < 8'd128);
        wr_acc      = wr_pvld & wr_prdy;

        // Credits: every in-flight read already owns a queue slot.
        q_after_pop = 4'(q_cnt_q) - 4'(pop);
        q_busy      = 4'(s1_q) + 4'(s2_q) + q_after_pop;
        issue       = !rst && (ram_cnt_q != 8'd0) && (q_busy < 4'd4);

`ifdef NV_FIFO_CTL_BYPASS_EN
        bypass      = wr_acc && (ram_cnt_q == 8'd0) && !s1_q && !s2_q && (q_after_pop < 4'd4);
`else
        bypass      = 1'b0;
`endif

        ram_we      = wr_acc && !bypass;
        ram_wa      = wr_ptr_q;
        ram_di      = ram_we ? wr_pd : 6'd0;
        ram_re      = issue;
        ram_ra      = rd_ptr_q;
        ram_ore     = s1_q;

        // Bypass requires s2 low, so at most one push source is active.
        push        = s2_q || bypass;
        push_data   = bypass ? wr_pd : ram_dout;

        rd_pd       = rd_pvld ? q_mem_q[q_rp_q] : 6'd0;
        count       = count_q;

        ram_pwrbus_ram_pd = pwrbus_ram_pd;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + 7'(ram_we);
        rd_ptr_d  = rd_ptr_q + 7'(issue);
        ram_cnt_d = ram_cnt_q + 8'(ram_we) - 8'(issue);
        s1_d      = issue;
        s2_d      = s1_q;
        q_cnt_d   = q_cnt_q + 3'(push) - 3'(pop);
        q_wp_d    = q_wp_q + 2'(push);
        q_rp_d    = q_rp_q + 2'(pop);
        count_d   = count_q + 8'(wr_acc) - 8'(pop);
        for (int i = 0; i < 4; i++) begin
            q_mem_d[i] = q_mem_q[i];
        end
        if (push) begin
            q_mem_d[q_wp_q] = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= 7'd0;
            rd_ptr_q  <= 7'd0;
            ram_cnt_q <= 8'd0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            q_cnt_q   <= 3'd0;
            q_wp_q    <= 2'd0;
            q_rp_q    <= 2'd0;
            count_q   <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            q_cnt_q   <= q_cnt_d;
            q_wp_q    <= q_wp_d;
            q_rp_q    <= q_rp_d;
            count_q   <= count_d;
        end
    end

    // Queue storage needs no reset; rd_pd is masked while the queue is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            q_mem_q[i] <= q_mem_d[i];
        end
    end

endmodule
